ifetch_queue: RTL
=================

# ifetch_queue

Parametrised instruction-fetch front end for the tamarisc pipeline. It replaces the single-register fetch stage with a DEPTH-entry prefetch queue. It keeps issuing sequential requests to the synchronous instruction memory while decode is stalled, discards wrong-path fetches on a redirect, and presents instruction/PC pairs to decode under a valid/stall handshake. It sits between the instruction memory port and the decode stage; control and datapath consume `inst_o`/`inst_pc_o`.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, 32'h0000_0013: value driven on `inst_o` when the queue is empty (`addi x0,x0,0`).

Ports:
- Reset is asynchronous, active-low. One clock.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `im_addr_o`  out  32  fetch address; always equals the fetch PC register.
- `im_req_o`  out  1  request strobe; memory returns data one cycle later.
- `im_dout_i`  in  32  memory read data, valid the cycle after `im_req_o`.
- `redirect_i`  in  1  branch/jump taken; flush the queue and refetch.
- `redirect_pc_i`  in  32  target address, sampled when `redirect_i` = 1.
- `stall_i`  in  1  decode cannot accept this cycle.
- `inst_o`  out  32  head instruction, or `NOP_INST` when not valid.
- `inst_pc_o`  out  32  PC of head instruction, or 0 when not valid.
- `inst_valid_o`  out  1  head entry valid.
- `count_o`  out  $clog2(DEPTH)+1  occupancy, for debug and perf counters.

## Operation
- State:
  - Fetch PC register `fpc`.
  - In-flight flag `inflt` and in-flight PC `ipc`.
  - Circular buffer of {inst, pc} with `rd_ptr`/`wr_ptr` ($clog2(DEPTH) bits, natural wrap) and `count`.
- Request rule: `im_req_o` = `rst_n_i` & !`redirect_i` & (`count` + `inflt` < DEPTH).
  - On a request: `inflt`←1, `ipc`←`fpc`, `fpc`←`fpc`+4 (mod 2^32).
  - Otherwise `inflt`←0.
- Push: when `inflt`=1 and no redirect, write {`im_dout_i`, `ipc`} at `wr_ptr`. The request rule guarantees the queue is never full when a push occurs.
- Pop: `inst_valid_o` & !`stall_i` & !`redirect_i` advances `rd_ptr`.
- Simultaneous push and pop: `count` unchanged and both pointers advance.
- Redirect (highest priority):
  - `count`, `rd_ptr`, `wr_ptr` ← 0.
  - `inflt`←0, which discards the response arriving next cycle.
  - `fpc`←`redirect_pc_i`.
  - No request in the redirect cycle.
  - `inst_valid_o` forced to 0 in the redirect cycle.
- `redirect_i` asserted on consecutive cycles: the last target wins; nothing is fetched until it deasserts.
- Outputs when `count`=0 (and no bypass): `inst_o`=`NOP_INST`, `inst_pc_o`=0.

## Timing
- Reset values:
  - `fpc`=`RESET_PC`, so `im_addr_o`=`RESET_PC`.
  - `im_req_o`=0 while `rst_n_i` is low.
  - `inst_valid_o`=0, `inst_o`=`NOP_INST`, `inst_pc_o`=0, `count_o`=0.
  - Pointers and `inflt` = 0.
- Reset mid-operation clears everything asynchronously. In-flight data is lost.
- Cycle 0 after reset release: request at `RESET_PC`.
  - Cycle 1: data pushed at the clock edge.
  - Cycle 2: `inst_valid_o`=1. This is 1 cycle earlier with bypass (see Configuration).
- Redirect at edge N:
  - Request at the target in cycle N+1.
  - Target instruction valid in cycle N+3, or N+2 with bypass.
- Steady state with `stall_i`=0: one instruction per cycle, sustained.
- With `stall_i`=1 held: occupancy rises to DEPTH, then `im_req_o`=0.
- One request is outstanding at most; the memory must not stall.

## Configuration
- `IFQ_BYPASS_EN` defined:
  - When `count`=0, `inflt`=1 and no redirect, drive `inst_o`=`im_dout_i`, `inst_pc_o`=`ipc`, `inst_valid_o`=1 combinationally.
  - If popped in that cycle, the entry is not written to the queue. If stalled, it is pushed as normal.
  - Saves one cycle of fetch-to-decode latency.
- Undefined: all instructions pass through the queue. Outputs are purely register/queue driven, with no path from `im_dout_i` to `inst_o`.

## Test plan
- Reset fill, `stall_i`=0, memory word at address A equals A:
  - Requests 0x0, 0x4, 0x8…
  - `inst_valid_o` rises in cycle 2 (cycle 1 with bypass).
  - `inst_o`/`inst_pc_o` = 0x0/0x0, then 0x4/0x4… one per cycle.
- Hold `stall_i`=1 from reset, DEPTH=4:
  - Exactly 4 requests.
  - `count_o` reaches 4 and `im_req_o` stays 0.
  - Head holds 0x0.
  - Release: 0x0, 0x4, 0x8, 0xC, 0x10 delivered on consecutive cycles.
- Redirect to 0x100 while the queue holds 3 entries and one request is in flight:
  - `count_o`=0 next cycle; the in-flight response is not pushed.
  - Next `inst_pc_o` with valid = 0x100, followed by 0x104.
- Redirect to 0x200 in a cycle where decode would pop:
  - No pop; `inst_valid_o`=0 in that cycle.
  - Old entries never reappear.
- `fpc`=0xFFFF_FFFC, no stall:
  - Next request address is 0x0 (wrap).
  - Pointer wrap is exercised by streaming 3×DEPTH instructions with alternating stall; verify no loss or duplication.
- Assert `rst_n_i` low mid-stream with `count_o`=2:
  - All outputs immediately return to their reset values.
  - After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end with a DEPTH-entry prefetch queue.
// It keeps issuing sequential fetches while decode is stalled. On a redirect
// it discards wrong-path fetches. It presents {inst, pc} to decode under a
// valid/stall handshake.
//
// Optional feature macro: IFQ_BYPASS_EN. When it is defined, a response that
// arrives while the queue is empty is forwarded straight to decode in the same
// cycle, which saves one cycle of fetch-to-decode latency.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   im_addr_o/im_req_o   fetch address / request strobe to the synchronous imem
//   im_dout_i            imem read data, valid the cycle after a request
//   redirect_i/_pc_i     flush the queue and refetch from the target
//   stall_i              decode cannot accept this cycle
//   inst_o/inst_pc_o     head instruction and its PC (NOP_INST / 0 when invalid)
//   inst_valid_o         head valid
//   count_o              queue occupancy
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  output logic [31:0]                im_addr_o,
  output logic                       im_req_o,
  input  logic [31:0]                im_dout_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  input  logic                       stall_i,
  output logic [31:0]                inst_o,
  output logic [31:0]                inst_pc_o,
  output logic                       inst_valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   ipc_q, ipc_d;
  logic          inflt_q, inflt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] occ;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          pop, push, q_pop;

  // Occupancy includes the outstanding fetch. This guarantees that the
  // response always finds a free slot.
  assign occ       = count_q + CW'(inflt_q);
  assign im_req_o  = rst_n_i & ~redirect_i & (occ < CW'(DEPTH));
  assign im_addr_o = fpc_q;
  assign count_o   = count_q;

  always_comb begin
    inst_o       = NOP_INST;
    inst_pc_o    = '0;
    inst_valid_o = 1'b0;
    if (!redirect_i) begin
      if (count_q != '0) begin
        inst_o       = inst_q[rd_ptr_q];
        inst_pc_o    = pc_q[rd_ptr_q];
        inst_valid_o = 1'b1;
      end
`ifdef IFQ_BYPASS_EN
      else if (inflt_q) begin
        inst_o       = im_dout_i;
        inst_pc_o    = ipc_q;
        inst_valid_o = 1'b1;
      end
`endif
    end
  end

  assign pop   = inst_valid_o & ~stall_i & ~redirect_i;
  assign q_pop = pop & (count_q != '0);
`ifdef IFQ_BYPASS_EN
  // A bypassed response that decode consumes is never written to the queue.
  assign push  = inflt_q & ~redirect_i & ~(pop & (count_q == '0));
`else
  assign push  = inflt_q & ~redirect_i;
`endif

  always_comb begin
    fpc_d    = fpc_q;
    ipc_d    = ipc_q;
    inflt_d  = im_req_o;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      fpc_d    = redirect_pc_i;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (im_req_o) begin
        ipc_d = fpc_q;
        fpc_d = fpc_q + 32'd4;
      end
      if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (q_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(q_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fpc_q    <= RESET_PC;
      ipc_q    <= '0;
      inflt_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      ipc_q    <= ipc_d;
      inflt_q  <= inflt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage is not reset. Every read of it is qualified by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_q[wr_ptr_q] <= im_dout_i;
      pc_q[wr_ptr_q]   <= ipc_q;
    end
  end
endmodule
